// File: rtl/dma_ctrl_pkg.sv
// Shared types and constants for the DMA command path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dma_ctrl_pkg;

    localparam int NUM_REQ_DEF = 2;
    localparam int ADDR_W      = 32;
    localparam int LEN_W       = 30;
    localparam int CNT_W       = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DONE = 3'd2,
        ST_RESP      = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    typedef struct packed {
        logic              dir;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } cmd_t;

    // A command the shim cannot execute: empty, or not word aligned.
    function automatic logic cmd_is_bad(input cmd_t c);
        return (c.len == '0) || (c.addr[1:0] != 2'b00);
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with its priority pointer.
// Latency: grant is combinational from req/enable; pointer moves on the edge after a grant.
// Backpressure: no grant while enable is low; a granted request is taken as accepted.
//
// Ports: clk/resetn; enable (arbitration window), req[1:0] (requests),
//        grant[1:0] (one-hot grant), grant_idx (index of the winner).
module rr_arbiter2 (
    input  logic       clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic [1:0] req,
    output logic [1:0] grant,
    output logic       grant_idx
);

    // Requester favoured when both request; the one not granted last.
    logic prio;

    always_comb begin
        grant_idx = 1'b0;
        case (req)
            2'b01:   grant_idx = 1'b0;
            2'b10:   grant_idx = 1'b1;
            2'b11:   grant_idx = prio;
            default: grant_idx = 1'b0;
        endcase
    end

    always_comb begin
        grant = 2'b00;
        if (enable && (req != 2'b00)) begin
            grant = grant_idx ? 2'b10 : 2'b01;
        end
    end

    // Every grant is an accept, so the pointer moves even if the
    // command is later rejected as malformed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prio <= 1'b0;
        end else if (grant != 2'b00) begin
            prio <= ~grant_idx;
        end
    end

endmodule

// File: rtl/dma_cmd_arbiter.sv
// Arbitrates two requesters onto one DMA shim, one command in flight, with timeout/halt.
// Latency: accept->start 1 cycle; shim done->req_done 1 cycle; malformed accept->req_done 1 cycle.
// Backpressure: req_ready only in IDLE for the round-robin winner; HALT blocks until clear_err.
//
// Ports: req_valid/req_ready/req_dir/req_addr/req_len (per-requester command),
//        req_done/req_err (completion pulse), dma_* (shim command + done),
//        clear_err (leave HALT), busy/cur_owner/timeout_sticky (status).
module dma_cmd_arbiter
    import dma_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int          NUM_REQ        = NUM_REQ_DEF
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_dir,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*LEN_W-1:0]  req_len,
    output logic [NUM_REQ-1:0]        req_done,
    output logic [NUM_REQ-1:0]        req_err,
    output logic                      dma_start_transfer,
    output logic                      dma_direction,
    output logic [ADDR_W-1:0]         dma_ddr_addr,
    output logic [LEN_W-1:0]          dma_length_bytes,
    input  logic                      dma_transfer_done,
    input  logic                      clear_err,
    output logic                      busy,
    output logic                      cur_owner,
    output logic                      timeout_sticky
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [1:0]       grant;
    logic             grant_idx;
    logic             accept;
    logic             timeout_hit;
    logic             resp_err;
    logic [CNT_W-1:0] wait_cnt;
    cmd_t             sel_cmd;
    logic             sel_bad;

    rr_arbiter2 u_arb (
        .clk       (clk),
        .resetn    (resetn),
        .enable    (state == ST_IDLE),
        .req       (req_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready is gated by reset so every output reads 0 while resetn is low.
    assign req_ready = grant & {2{resetn}};
    assign accept    = (req_valid & req_ready) != 2'b00;

    always_comb begin
        sel_cmd.dir  = grant_idx ? req_dir[1] : req_dir[0];
        sel_cmd.addr = grant_idx ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
        sel_cmd.len  = grant_idx ? req_len[LEN_W +: LEN_W] : req_len[0 +: LEN_W];
        sel_bad      = cmd_is_bad(sel_cmd);
    end

    // Done has priority over a timeout landing in the same cycle.
    assign timeout_hit = (state == ST_WAIT_DONE) && !dma_transfer_done && (wait_cnt == TMO_LAST);

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = sel_bad ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE:     state_nxt = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (dma_transfer_done || timeout_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP:      state_nxt = timeout_sticky ? ST_HALT : ST_IDLE;
            ST_HALT: begin
                if (clear_err) begin
                    state_nxt = ST_IDLE;
                end
            end
            default:      state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy               = (state != ST_IDLE);
        dma_start_transfer = (state == ST_ISSUE);
        req_done           = 2'b00;
        req_err            = 2'b00;
        if (state == ST_RESP) begin
            req_done = {cur_owner, ~cur_owner};
            req_err  = resp_err ? {cur_owner, ~cur_owner} : 2'b00;
        end
    end

    // Command latch; held until the next accept, rejected commands included.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dma_direction    <= 1'b0;
            dma_ddr_addr     <= '0;
            dma_length_bytes <= '0;
            cur_owner        <= 1'b0;
        end else if (accept) begin
            dma_direction    <= sel_cmd.dir;
            dma_ddr_addr     <= sel_cmd.addr;
            dma_length_bytes <= sel_cmd.len;
            cur_owner        <= grant_idx;
        end
    end

    // Response error, timeout counter and sticky flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_err       <= 1'b0;
            wait_cnt       <= '0;
            timeout_sticky <= 1'b0;
        end else begin
            // Counter runs only in WAIT_DONE, so it is 0 on the entry cycle.
            wait_cnt <= (state == ST_WAIT_DONE) ? wait_cnt + 1'b1 : '0;

            if (accept) begin
                resp_err <= sel_bad;
            end else if (state == ST_WAIT_DONE) begin
                if (dma_transfer_done) begin
                    resp_err <= 1'b0;
                end else if (timeout_hit) begin
                    resp_err       <= 1'b1;
                    timeout_sticky <= 1'b1;
                end
            end

            if ((state == ST_HALT) && clear_err) begin
                timeout_sticky <= 1'b0;
            end
        end
    end

endmodule

// File: doc/dma_cmd_arbiter.md
DMA_CMD_ARBITER -- requirements
Module: dma_cmd_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, max cycles to wait for shim done before aborting.
REQ-002 Parameter NUM_REQ, default 2, number of requesters; fixed at 2 for this release.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 resetn  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  2  per-requester command valid.
REQ-006 req_ready  out  2  per-requester command accept.
REQ-007 req_dir  in  2  per-requester direction; 1=MM2S, 0=S2MM.
REQ-008 req_addr  in  64  per-requester DDR byte address; [32i+31:32i] is requester i.
REQ-009 req_len  in  60  per-requester length in bytes; [30i+29:30i] is requester i.
REQ-010 req_done  out  2  one-cycle completion pulse to the owning requester.
REQ-011 req_err  out  2  one-cycle error qualifier, valid only with req_done.
REQ-012 dma_start_transfer  out  1  one-cycle start pulse to the DMA shim.
REQ-013 dma_direction  out  1  latched direction to the shim.
REQ-014 dma_ddr_addr  out  32  latched address to the shim.
REQ-015 dma_length_bytes  out  30  latched byte length to the shim.
REQ-016 dma_transfer_done  in  1  one-cycle done pulse from the shim.
REQ-017 clear_err  in  1  releases HALT state.
REQ-018 busy  out  1  high in any state other than IDLE.
REQ-019 cur_owner  out  1  index of the requester owning the current command.
REQ-020 timeout_sticky  out  1  set on timeout; cleared by clear_err.

Function
REQ-021 States: IDLE, ISSUE, WAIT_DONE, RESP, HALT.
REQ-022 IDLE: req_ready[i] high only for the arbitration winner i, combinational from req_valid and the priority pointer; all ready bits are low in other states.
REQ-023 Round-robin arbitration: a lone valid requester wins; when both are valid, the requester not granted last wins.
REQ-024 Priority pointer updates on every accept, including rejected commands.
REQ-025 On accept (valid & ready): latch dir/addr/len/owner into the dma_* outputs and cur_owner.
REQ-026 Validity check on the accepted command: len==0 or addr[1:0]!=0 skips ISSUE; next state is RESP with err=1.
REQ-027 A valid command goes to ISSUE.
REQ-028 ISSUE lasts exactly one cycle, asserting dma_start_transfer, then goes to WAIT_DONE.
REQ-029 Accept-to-start latency is 1 cycle.
REQ-030 WAIT_DONE: a 32-bit counter starts at 0 and increments each cycle.
REQ-031 WAIT_DONE: dma_transfer_done goes to RESP with err=0.
REQ-032 WAIT_DONE: counter == TIMEOUT_CYCLES-1 without done goes to RESP with err=1 and sets timeout_sticky.
REQ-033 Done and timeout in the same cycle: done wins, err=0.
REQ-034 RESP lasts one cycle, pulsing req_done[owner] with req_err[owner] as determined; done-to-resp latency is 1 cycle.
REQ-035 RESP next state: HALT if timeout_sticky, else IDLE.
REQ-036 HALT: no commands are accepted; clear_err clears timeout_sticky and moves to IDLE next cycle.
REQ-037 clear_err in any state other than HALT is ignored.
REQ-038 dma_transfer_done outside WAIT_DONE is ignored and counted nowhere.
REQ-039 dma_* data outputs hold their last value until the next accept.
REQ-040 Throughput: at most one command in flight; a new command may be accepted in the cycle after RESP.

Reset
REQ-041 resetn low: state=IDLE, priority pointer favours requester 0, and the counter clears.
REQ-042 resetn low: every output is 0, including all dma_*, req_done, req_err, busy, cur_owner and timeout_sticky.
REQ-043 A command in flight during reset is dropped with no req_done issued.

Structure
REQ-044 Shared package dma_ctrl_pkg holds the state encoding, the NUM_REQ default, and the width constants for address (32) and length (30).
REQ-045 Sub-module rr_arbiter2 holds the 2-way round-robin grant and its pointer; FSM, latches and timeout live in the top.

Verification
REQ-046 req0 only, dir=1, addr=0x1000_0000, len=256; done 20 cycles after start -> start 1 cycle after accept, dma_* match, req_done[0] with err=0 one cycle after done.
REQ-047 req0 and req1 valid simultaneously for 4 back-to-back commands -> grants 0,1,0,1 and cur_owner matches each req_done.
REQ-048 req1 len=0, and separately req1 addr=0x1002 -> no start pulse; req_done[1] & req_err[1] 1 cycle after accept.
REQ-049 TIMEOUT_CYCLES=16, no done -> req_err pulse 16 cycles after WAIT_DONE entry and timeout_sticky=1; ready stays low until clear_err, then IDLE.
REQ-050 Done in the same cycle as timeout (TIMEOUT_CYCLES=16) -> err=0 and no HALT.
REQ-051 resetn low during WAIT_DONE -> all outputs 0, no req_done; stray dma_transfer_done after reset is ignored.
